// File: rtl/hh_membrane_update.sv
// Hodgkin-Huxley membrane update: computes Na/K/leak currents with one shared
// 64-bit multiplier over a fixed 12-state micro-op sequence, then one Euler step on V.
module hh_membrane_update #(
  parameter int G_NA   = 1200,
  parameter int G_K    = 360,
  parameter int G_L    = 3,
  parameter int E_NA   = 5000,
  parameter int E_K    = -7700,
  parameter int E_L    = -5440,
  parameter int V_REST = -6500
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic signed [15:0] m,
  input  logic signed [15:0] h,
  input  logic signed [15:0] n,
  input  logic signed [15:0] i_ext,
  input  logic        [15:0] dt_us,
  output logic signed [15:0] v_q,
  output logic signed [15:0] v_mv,
  output logic signed [31:0] i_ion,
  output logic               busy,
  output logic               done
);

  typedef enum logic [3:0] {
    IDLE, S1, S2, S3, S4, S5, S6, S7, S8, S9, S10, S11, S12
  } state_t;

  state_t state_q, state_d;

  logic signed [15:0] m_q, m_d, h_q, h_d, n_q, n_d;
  logic signed [15:0] iext_q, iext_d;
  logic        [15:0] dt_q, dt_d;
  logic signed [15:0] vc_q, vc_d;
  logic signed [31:0] m2_q, m2_d, m3_q, m3_d, g_q, g_d;
  logic signed [31:0] n2_q, n2_d, n4_q, n4_d, t_q, t_d;
  logic signed [31:0] i_na_q, i_na_d, i_k_q, i_k_d, i_l_q, i_l_d, i_net_q, i_net_d;
  logic signed [31:0] i_ion_q, i_ion_d;
  logic signed [15:0] v_d, v_mv_q, v_mv_d;
  logic               done_q, done_d;

  logic signed [63:0] mul_a, mul_b, prod, q1000, q10000, vsum;

  function automatic logic signed [15:0] clamp_gate(input logic signed [15:0] x);
    if (x < 16'sd0)
      return '0;
    else if (x > 16'sd1000)
      return 16'sd1000;
    else
      return x;
  endfunction

  // Shared multiplier operand selection
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    unique case (state_q)
      S1:  begin mul_a = 64'(m_q);     mul_b = 64'(m_q);                end
      S2:  begin mul_a = 64'(m2_q);    mul_b = 64'(m_q);                end
      S3:  begin mul_a = 64'(m3_q);    mul_b = 64'(h_q);                end
      S4:  begin mul_a = 64'(n_q);     mul_b = 64'(n_q);                end
      S5:  begin mul_a = 64'(n2_q);    mul_b = 64'(n2_q);               end
      S6:  begin mul_a = 64'(G_NA);    mul_b = 64'(g_q);                end
      S7:  begin mul_a = 64'(t_q);     mul_b = 64'(vc_q) - 64'(E_NA);   end
      S8:  begin mul_a = 64'(G_K);     mul_b = 64'(n4_q);               end
      S9:  begin mul_a = 64'(t_q);     mul_b = 64'(vc_q) - 64'(E_K);    end
      S10: begin mul_a = 64'(G_L);     mul_b = 64'(vc_q) - 64'(E_L);    end
      S12: begin mul_a = 64'(i_net_q); mul_b = {48'h0, dt_q};           end
      default: ;
    endcase
  end

  assign prod   = mul_a * mul_b;
  assign q1000  = prod / 64'sd1000;
  assign q10000 = prod / 64'sd10000;
  assign vsum   = 64'(vc_q) + q10000;

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    h_d     = h_q;
    n_d     = n_q;
    iext_d  = iext_q;
    dt_d    = dt_q;
    vc_d    = vc_q;
    m2_d    = m2_q;
    m3_d    = m3_q;
    g_d     = g_q;
    n2_d    = n2_q;
    n4_d    = n4_q;
    t_d     = t_q;
    i_na_d  = i_na_q;
    i_k_d   = i_k_q;
    i_l_d   = i_l_q;
    i_net_d = i_net_q;
    i_ion_d = i_ion_q;
    v_d     = v_q;
    v_mv_d  = v_mv_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          m_d     = clamp_gate(m);
          h_d     = clamp_gate(h);
          n_d     = clamp_gate(n);
          iext_d  = i_ext;
          dt_d    = dt_us;
          vc_d    = v_q;
          state_d = S1;
        end
      end
      S1:  begin m2_d  = 32'(q1000); state_d = S2;  end
      S2:  begin m3_d  = 32'(q1000); state_d = S3;  end
      S3:  begin g_d   = 32'(q1000); state_d = S4;  end
      S4:  begin n2_d  = 32'(q1000); state_d = S5;  end
      S5:  begin n4_d  = 32'(q1000); state_d = S6;  end
      S6:  begin t_d   = 32'(prod);  state_d = S7;  end
      S7:  begin i_na_d = 32'(q1000); state_d = S8; end
      S8:  begin t_d   = 32'(prod);  state_d = S9;  end
      S9:  begin i_k_d = 32'(q1000); state_d = S10; end
      S10: begin i_l_d = 32'(prod);  state_d = S11; end
      S11: begin
        i_net_d = 32'(iext_q) - i_na_q - i_k_q - i_l_q;
        i_ion_d = i_na_q + i_k_q + i_l_q;
        state_d = S12;
      end
      S12: begin
        if (vsum > 64'sd32767)
          v_d = 16'sh7FFF;
        else if (vsum < -64'sd32768)
          v_d = 16'sh8000;
        else
          v_d = 16'(vsum);
        v_mv_d  = v_d / 16'sd100;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      m_q     <= '0;
      h_q     <= '0;
      n_q     <= '0;
      iext_q  <= '0;
      dt_q    <= '0;
      vc_q    <= '0;
      m2_q    <= '0;
      m3_q    <= '0;
      g_q     <= '0;
      n2_q    <= '0;
      n4_q    <= '0;
      t_q     <= '0;
      i_na_q  <= '0;
      i_k_q   <= '0;
      i_l_q   <= '0;
      i_net_q <= '0;
      i_ion_q <= '0;
      v_q     <= 16'(V_REST);
      v_mv_q  <= 16'(V_REST / 100);
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      h_q     <= h_d;
      n_q     <= n_d;
      iext_q  <= iext_d;
      dt_q    <= dt_d;
      vc_q    <= vc_d;
      m2_q    <= m2_d;
      m3_q    <= m3_d;
      g_q     <= g_d;
      n2_q    <= n2_d;
      n4_q    <= n4_d;
      t_q     <= t_d;
      i_na_q  <= i_na_d;
      i_k_q   <= i_k_d;
      i_l_q   <= i_l_d;
      i_net_q <= i_net_d;
      i_ion_q <= i_ion_d;
      v_q     <= v_d;
      v_mv_q  <= v_mv_d;
      done_q  <= done_d;
    end
  end

  assign v_mv  = v_mv_q;
  assign i_ion = i_ion_q;
  assign busy  = (state_q != IDLE);
  assign done  = done_q;

endmodule

// File: tb/tb_hh_membrane_update.sv
// Self-checking bench for hh_membrane_update: directed plan cases plus randomized
// steps against a plain-arithmetic Hodgkin-Huxley Euler model.
module tb_hh_membrane_update;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               start = 1'b0;
  logic signed [15:0] m = '0, h = '0, n = '0, i_ext = '0;
  logic        [15:0] dt_us = '0;
  logic signed [15:0] v_q, v_mv;
  logic signed [31:0] i_ion;
  logic               busy, done;

  int checks = 0;
  int errors = 0;
  int model_v = -6500;

  hh_membrane_update #(
    .G_NA(1200), .G_K(360), .G_L(3),
    .E_NA(5000), .E_K(-7700), .E_L(-5440), .V_REST(-6500)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .m(m), .h(h), .n(n), .i_ext(i_ext), .dt_us(dt_us),
    .v_q(v_q), .v_mv(v_mv), .i_ion(i_ion), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic longint clampg(input longint x);
    return (x < 0) ? 0 : ((x > 1000) ? 1000 : x);
  endfunction

  // One Euler step of the membrane equation, evaluated directly in 64-bit integers.
  function automatic void model_step(input int mi, input int hi, input int ni,
                                     input int ie, input int dt, input int v,
                                     output int v_new, output int ion);
    longint mm, hh, nn, gna, n4, ina, ik, il, inet, vs;
    mm   = clampg(mi);
    hh   = clampg(hi);
    nn   = clampg(ni);
    gna  = ((mm * mm / 1000) * mm / 1000) * hh / 1000;
    n4   = (nn * nn / 1000) * (nn * nn / 1000) / 1000;
    ina  = 1200 * gna * (v - 5000) / 1000;
    ik   = 360 * n4 * (v + 7700) / 1000;
    il   = 3 * (v + 5440);
    inet = ie - ina - ik - il;
    vs   = v + (inet * dt) / 10000;
    if (vs > 32767) vs = 32767;
    if (vs < -32768) vs = -32768;
    v_new = int'(vs);
    ion   = int'(ina + ik + il);
  endfunction

  task automatic apply_reset();
    reset = 1'b0;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    model_v = -6500;
  endtask

  // Drives one step; inputs are scrambled after capture. cyc = edges from start to done.
  task automatic run_step(input int mi, input int hi, input int ni, input int ie,
                          input int dt, output int cyc, output logic busy1);
    m = 16'(mi); h = 16'(hi); n = 16'(ni); i_ext = 16'(ie); dt_us = 16'(dt);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    busy1 = busy;
    m = 16'($urandom); h = 16'($urandom); n = 16'($urandom);
    i_ext = 16'($urandom); dt_us = 16'($urandom);
    cyc = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1 cyc++;
      if (done) break;
    end
  endtask

  task automatic test_reset();
    int dcount = 0;
    apply_reset();
    checks++; if (v_q !== -16'sd6500) begin errors++; $display("FAIL reset_v got %0d want -6500", v_q); end
    checks++; if (v_mv !== -16'sd65) begin errors++; $display("FAIL reset_vmv got %0d want -65", v_mv); end
    checks++; if (i_ion !== 32'sd0) begin errors++; $display("FAIL reset_iion got %0d want 0", i_ion); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1 if (done) dcount++;
    end
    checks++; if (dcount != 0) begin errors++; $display("FAIL reset_no_done got %0d want 0", dcount); end
  endtask

  task automatic test_zero_gates();
    int cyc; logic b1;
    apply_reset();
    run_step(0, 0, 0, 0, 10, cyc, b1);
    checks++; if (b1 !== 1'b1) begin errors++; $display("FAIL zero_busy got %b want 1", b1); end
    checks++; if (cyc != 12) begin errors++; $display("FAIL zero_latency got %0d want 12", cyc); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy_done got %b want 0", busy); end
    checks++; if (i_ion !== -32'sd3180) begin errors++; $display("FAIL zero_iion got %0d want -3180", i_ion); end
    checks++; if (v_q !== -16'sd6497) begin errors++; $display("FAIL zero_v got %0d want -6497", v_q); end
    checks++; if (v_mv !== -16'sd64) begin errors++; $display("FAIL zero_vmv got %0d want -64", v_mv); end
    @(posedge clk);
    #1 checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_done_pulse got %b want 0", done); end
  endtask

  task automatic test_na_full();
    int cyc; logic b1;
    apply_reset();
    run_step(1000, 1000, 0, 0, 10, cyc, b1);
    checks++; if (i_ion !== -32'sd13803180) begin errors++; $display("FAIL na_iion got %0d want -13803180", i_ion); end
    checks++; if (v_q !== 16'sd7303) begin errors++; $display("FAIL na_v got %0d want 7303", v_q); end
    checks++; if (v_mv !== 16'sd73) begin errors++; $display("FAIL na_vmv got %0d want 73", v_mv); end
  endtask

  task automatic test_k_full();
    int cyc; logic b1;
    apply_reset();
    run_step(0, 0, 1000, 0, 10, cyc, b1);
    checks++; if (i_ion !== 32'sd428820) begin errors++; $display("FAIL k_iion got %0d want 428820", i_ion); end
    checks++; if (v_q !== -16'sd6928) begin errors++; $display("FAIL k_v got %0d want -6928", v_q); end
    checks++; if (v_mv !== -16'sd69) begin errors++; $display("FAIL k_vmv got %0d want -69", v_mv); end
  endtask

  task automatic test_saturation();
    int cyc, ev, eion; logic b1;
    apply_reset();
    run_step(0, 0, 0, 32767, 65535, cyc, b1);
    checks++; if (v_q !== 16'sd32767) begin errors++; $display("FAIL sat_v got %0d want 32767", v_q); end
    checks++; if (v_mv !== 16'sd327) begin errors++; $display("FAIL sat_vmv got %0d want 327", v_mv); end
    model_step(0, 0, 0, 32767, 65535, 32767, ev, eion);
    run_step(0, 0, 0, 32767, 65535, cyc, b1);
    checks++; if (v_q !== 16'(ev)) begin errors++; $display("FAIL sat_repeat_v got %0d want %0d", v_q, ev); end
    checks++; if (i_ion !== eion) begin errors++; $display("FAIL sat_repeat_iion got %0d want %0d", i_ion, eion); end
  endtask

  task automatic test_clamp();
    int cyc; logic b1;
    logic signed [15:0] v_ref; logic signed [31:0] ion_ref;
    apply_reset();
    run_step(1000, 0, 0, 500, 100, cyc, b1);
    v_ref = v_q; ion_ref = i_ion;
    apply_reset();
    run_step(1500, -5, 0, 500, 100, cyc, b1);
    checks++; if (v_q !== v_ref) begin errors++; $display("FAIL clamp_v got %0d want %0d", v_q, v_ref); end
    checks++; if (i_ion !== ion_ref) begin errors++; $display("FAIL clamp_iion got %0d want %0d", i_ion, ion_ref); end
    checks++; if (i_ion !== -32'sd3180) begin errors++; $display("FAIL clamp_abs_iion got %0d want -3180", i_ion); end
  endtask

  task automatic test_start_ignored();
    int dcount = 0, first = 0, ev, eion;
    apply_reset();
    model_step(800, 600, 300, 1000, 50, model_v, ev, eion);
    m = 16'sd800; h = 16'sd600; n = 16'sd300; i_ext = 16'sd1000; dt_us = 16'd50;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      start = (k == 3 || k == 7);
      @(posedge clk);
      #1 start = 1'b0;
      if (done) begin dcount++; if (first == 0) first = k; end
    end
    checks++; if (dcount != 1) begin errors++; $display("FAIL ign_done_count got %0d want 1", dcount); end
    checks++; if (first != 12) begin errors++; $display("FAIL ign_latency got %0d want 12", first); end
    checks++; if (v_q !== 16'(ev)) begin errors++; $display("FAIL ign_v got %0d want %0d", v_q, ev); end
    model_v = ev;
  endtask

  task automatic test_reset_mid();
    int cyc, dcount = 0; logic b1;
    apply_reset();
    run_step(0, 0, 0, 0, 10, cyc, b1);
    m = 16'sd1000; h = 16'sd1000; n = 16'sd0; i_ext = 16'sd0; dt_us = 16'd10;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    checks++; if (v_q !== -16'sd6500) begin errors++; $display("FAIL rmid_v got %0d want -6500", v_q); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b want 0", busy); end
    checks++; if (i_ion !== 32'sd0) begin errors++; $display("FAIL rmid_iion got %0d want 0", i_ion); end
    reset = 1'b1;
    model_v = -6500;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1 if (done) dcount++;
    end
    checks++; if (dcount != 0) begin errors++; $display("FAIL rmid_no_done got %0d want 0", dcount); end
    checks++; if (v_q !== -16'sd6500) begin errors++; $display("FAIL rmid_v_hold got %0d want -6500", v_q); end
  endtask

  task automatic test_back_to_back();
    int cyc, ev, eion; logic b1;
    apply_reset();
    for (int s = 0; s < 3; s++) begin
      model_step(200 * s, 900, 500, 20000, 40, model_v, ev, eion);
      run_step(200 * s, 900, 500, 20000, 40, cyc, b1);
      checks++; if (cyc != 12) begin errors++; $display("FAIL b2b_latency step %0d got %0d want 12", s, cyc); end
      checks++; if (v_q !== 16'(ev)) begin errors++; $display("FAIL b2b_v step %0d got %0d want %0d", s, v_q, ev); end
      model_v = ev;
    end
  endtask

  task automatic test_random();
    int cyc, mi, hi, ni, ie, dt, ev, eion; logic b1;
    apply_reset();
    for (int s = 0; s < 40; s++) begin
      mi = int'($urandom_range(0, 1400)) - 200;
      hi = int'($urandom_range(0, 1400)) - 200;
      ni = int'($urandom_range(0, 1400)) - 200;
      ie = int'($urandom_range(0, 65535)) - 32768;
      dt = (s % 8 == 7) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 100));
      model_step(mi, hi, ni, ie, dt, model_v, ev, eion);
      run_step(mi, hi, ni, ie, dt, cyc, b1);
      checks++; if (cyc != 12) begin errors++; $display("FAIL rnd_latency step %0d got %0d want 12", s, cyc); end
      checks++; if (i_ion !== eion) begin errors++; $display("FAIL rnd_iion step %0d got %0d want %0d", s, i_ion, eion); end
      checks++; if (v_q !== 16'(ev)) begin errors++; $display("FAIL rnd_v step %0d got %0d want %0d", s, v_q, ev); end
      checks++; if (v_mv !== 16'(ev / 100)) begin errors++; $display("FAIL rnd_vmv step %0d got %0d want %0d", s, v_mv, ev / 100); end
      model_v = ev;
      if (s % 10 == 9) apply_reset();
    end
  endtask

  initial begin
    test_reset();
    test_zero_gates();
    test_na_full();
    test_k_full();
    test_saturation();
    test_clamp();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
